// File: rtl/clk_div_prog.sv
// Runtime-programmable integer clock divider with 50% duty, period-aligned divisor updates and clean start/stop.
// Define CLKDIV_NEG_EN to add the negedge path that gives exact 50% duty for odd divisors.
module clk_div_prog #(
    parameter int unsigned W        = 8,
    parameter int unsigned DIV_INIT = 5
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic [W-1:0] div_i,
    input  logic         div_load,
    output logic         clkout,
    output logic         tick,
    output logic         running,
    output logic [W-1:0] div_cur,
    output logic         div_err
);
    localparam int unsigned WH = W + 1;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t       state, state_nxt;
    logic [W-1:0] cnt, cnt_nxt;
    logic [W-1:0] pending, pending_nxt;
    logic [W-1:0] div_cur_nxt;
    logic         pend_vld, pend_vld_nxt;
    logic         clkp, clkp_nxt;
    logic         tick_nxt;
    logic         div_err_nxt;
    logic         wrap;
    logic [WH-1:0] half;
    logic         run_n;
    logic         clk_odd;

    // State and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            pending  <= '0;
            pend_vld <= 1'b0;
            div_cur  <= W'(DIV_INIT);
            clkp     <= 1'b0;
            tick     <= 1'b0;
            running  <= 1'b0;
            div_err  <= 1'b0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            pending  <= pending_nxt;
            pend_vld <= pend_vld_nxt;
            div_cur  <= div_cur_nxt;
            clkp     <= clkp_nxt;
            tick     <= tick_nxt;
            running  <= (state_nxt != IDLE);
            div_err  <= div_err_nxt;
        end
    end

    // Next-state, counter and divisor-update logic
    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt;
        clkp_nxt     = clkp;
        div_cur_nxt  = div_cur;
        pending_nxt  = pending;
        pend_vld_nxt = pend_vld;
        div_err_nxt  = div_err;
        wrap         = (cnt == div_cur - W'(1));
        half         = (WH'(div_cur) + WH'(1)) >> 1;

        unique case (state)
            IDLE: begin
                if (pend_vld) begin
                    div_cur_nxt  = pending;
                    pend_vld_nxt = 1'b0;
                end
                cnt_nxt = '0;
                if (en) begin
                    state_nxt = RUN;
                    clkp_nxt  = 1'b1;
                end else begin
                    clkp_nxt  = 1'b0;
                end
            end
            RUN, DRAIN: begin
                if (wrap) begin
                    cnt_nxt = '0;
                    if (pend_vld) begin
                        div_cur_nxt  = pending;
                        pend_vld_nxt = 1'b0;
                    end
                    if (en) begin
                        state_nxt = RUN;
                        clkp_nxt  = 1'b1;
                    end else begin
                        state_nxt = IDLE;
                        clkp_nxt  = 1'b0;
                    end
                end else begin
                    cnt_nxt   = cnt + W'(1);
                    clkp_nxt  = (WH'(cnt_nxt) < half);
                    state_nxt = en ? RUN : DRAIN;
                end
            end
            default: begin
                state_nxt = IDLE;
                clkp_nxt  = 1'b0;
            end
        endcase

        // A load overrides pending after any apply this cycle, so it waits for the following wrap
        if (div_load) begin
            if (div_i != '0) begin
                pending_nxt  = div_i;
                pend_vld_nxt = 1'b1;
                div_err_nxt  = 1'b0;
            end else begin
                div_err_nxt  = 1'b1;
            end
        end

        tick_nxt = (state_nxt != IDLE) && (cnt_nxt == '0);
    end

    // Gate for N==1 changes only while clk is low
    always_ff @(negedge clk or posedge rst) begin
        if (rst) run_n <= 1'b0;
        else     run_n <= running;
    end

`ifdef CLKDIV_NEG_EN
    logic clkn;

    always_ff @(negedge clk or posedge rst) begin
        if (rst) clkn <= 1'b0;
        else     clkn <= clkp;
    end

    assign clk_odd = clkp & clkn;
`else
    assign clk_odd = clkp;
`endif

    // Output selection by divisor class
    always_comb begin
        if (div_cur == W'(1))
            clkout = clk & run_n;
        else if (div_cur[0])
            clkout = clk_odd;
        else
            clkout = clkp;
    end

endmodule
